// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: payload field widths and the fetch->decode
// payload layout that instantiators concatenate into pipe_stage_rv.in_data.
package pipe_pkg;

    localparam int unsigned PC_W         = 64;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned COMMIT_W     = 161;
    localparam int unsigned FD_PAYLOAD_W = PC_W + INSTR_W + COMMIT_W;

    // Fetch->decode payload, MSB-first: pc, instr, commit info.
    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [INSTR_W-1:0]  instr;
        logic [COMMIT_W-1:0] commit;
    } fd_payload_t;

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating performance counters for a pipeline stage output.
// Ports:
//   clk, rst       clock, asynchronous active-low reset (flush does not clear)
//   out_valid_i    stage output valid
//   out_ready_i    downstream ready
//   flush_i        stage flush
//   stall_cnt_o    cycles with out_valid & ~out_ready
//   bubble_cnt_o   cycles with ~out_valid
//   flush_cnt_o    cycles with flush high
module pipe_stage_perf #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_valid_i,
    input  logic              out_ready_i,
    input  logic              flush_i,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] bubble_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] bubble_q;
    logic [PERF_W-1:0] flush_q;

    // Each counter sticks at all-ones once reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (out_valid_i && !out_ready_i && (stall_q != '1)) begin
                stall_q <= stall_q + PERF_W'(1);
            end
            if (!out_valid_i && (bubble_q != '1)) begin
                bubble_q <= bubble_q + PERF_W'(1);
            end
            if (flush_i && (flush_q != '1)) begin
                flush_q <= flush_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
    assign flush_cnt_o  = flush_q;

endmodule

// File: rtl/pipe_stage_rv.sv
// Ready/valid pipeline stage register with optional two-entry skid buffer
// and synchronous flush. Payload is opaque (DATA_W bits).
// Optional feature macro: PIPE_STAGE_PERF_EN adds stall/bubble/flush counters.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   flush                synchronous flush, squashes all held entries
//   in_valid/in_ready    upstream handshake; in_data upstream payload
//   out_valid/out_ready  downstream handshake; out_data downstream payload
//   occupancy            entries held (0..2)
//   stall_cnt, bubble_cnt, flush_cnt  (PIPE_STAGE_PERF_EN only)
module pipe_stage_rv
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = FD_PAYLOAD_W,
    parameter int unsigned SKID_EN = 1,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] bubble_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_v_q & out_ready;

    // Upstream ready: registered from next skid state, or combinational when no skid.
    generate
        if (SKID_EN != 0) begin : g_skid_ready
            logic ready_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ready_q <= 1'b0;
                end else begin
                    ready_q <= ~skid_v_d;
                end
            end
            assign in_ready = ready_q;
        end else begin : g_comb_ready
            assign in_ready = rst & (~main_v_q | out_ready);
        end
    endgenerate

    // Next-state: flush first, then drain skid, then refill main, else park in skid.
    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_v_d    = 1'b0;
            main_data_d = '0;
            skid_v_d    = 1'b0;
            skid_data_d = '0;
        end else if ((SKID_EN != 0) && skid_v_q) begin
            if (out_fire) begin
                main_v_d    = 1'b1;
                main_data_d = skid_data_q;
                skid_v_d    = 1'b0;
                skid_data_d = '0;
            end
        end else if (!main_v_q || out_fire) begin
            // Zero data on an unrefilled slot so idle output reads as a nop.
            main_v_d    = in_fire;
            main_data_d = in_fire ? in_data : '0;
        end else if ((SKID_EN != 0) && in_fire) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_perf #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .out_valid_i  (main_v_q),
        .out_ready_i  (out_ready),
        .flush_i      (flush),
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt),
        .flush_cnt_o  (flush_cnt)
    );
`else
    logic unused_perf_w;
    assign unused_perf_w = ^PERF_W;
`endif

endmodule

// File: tb/tb_pipe_stage_rv.sv
// Bench for pipe_stage_rv: a skid instance and a no-skid instance share the
// same inputs; each is checked against a queue model of the stage.
module tb_pipe_stage_rv;

    localparam int unsigned DW   = 64;
    localparam int unsigned PW   = 4;
    localparam int          PMAX = (1 << PW) - 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;

    logic          s_in_ready, s_out_valid, n_in_ready, n_out_valid;
    logic [DW-1:0] s_out_data, n_out_data;
    logic [1:0]    s_occ, n_occ;
`ifdef PIPE_STAGE_PERF_EN
    logic [PW-1:0] s_stall, s_bubble, s_flush;
    logic [31:0]   n_stall, n_bubble, n_flush;
`endif

    int n_cmp;
    int n_err;

    logic [DW-1:0] qs[$];
    logic [DW-1:0] qn[$];
    bit            s_live;
    int            m_stall, m_bubble, m_flush;

    pipe_stage_rv #(.DATA_W(DW), .SKID_EN(1), .PERF_W(PW)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .occupancy(s_occ)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(s_stall), .bubble_cnt(s_bubble), .flush_cnt(s_flush)
`endif
    );

    pipe_stage_rv #(.DATA_W(DW), .SKID_EN(0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
        .occupancy(n_occ)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(n_stall), .bubble_cnt(n_bubble), .flush_cnt(n_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and apply the stage rules to the queue models.
    task automatic tick();
        bit fs, os, fn, on;
        @(posedge clk);
        if (rst) begin
            fs = in_valid && s_live && (qs.size() < 2);
            os = (qs.size() > 0) && out_ready;
            fn = in_valid && ((qn.size() == 0) || out_ready);
            on = (qn.size() > 0) && out_ready;
            if ((qs.size() > 0) && !out_ready && (m_stall < PMAX)) m_stall++;
            if ((qs.size() == 0) && (m_bubble < PMAX)) m_bubble++;
            if (flush && (m_flush < PMAX)) m_flush++;
            if (flush) begin
                qs.delete();
                qn.delete();
            end else begin
                if (os) void'(qs.pop_front());
                if (fs) qs.push_back(in_data);
                if (on) void'(qn.pop_front());
                if (fn) qn.push_back(in_data);
            end
            s_live = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        qs.delete();
        qn.delete();
        s_live   = 1'b0;
        m_stall  = 0;
        m_bubble = 0;
        m_flush  = 0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1'b1, DW'(12'hABC), 1'b0, 1'b0);
        do_reset();
        tick();
        #1;
        n_cmp++; if (s_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_in_ready got=%b exp=0", s_in_ready); end
        n_cmp++; if (n_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_n_in_ready got=%b exp=0", n_in_ready); end
        n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", s_out_valid); end
        n_cmp++; if (s_out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", s_out_data); end
        n_cmp++; if (s_occ !== 2'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", s_occ); end
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        #1;
        n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready got=%b exp=1", s_in_ready); end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0);
            tick();
            #1;
            n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== DW'(i)) begin
                n_err++; $display("FAIL stream_s i=%0d got=%b/%h exp=1/%h", i, s_out_valid, s_out_data, DW'(i));
            end
            n_cmp++; if (n_out_valid !== 1'b1 || n_out_data !== DW'(i)) begin
                n_err++; $display("FAIL stream_n i=%0d got=%b/%h exp=1/%h", i, n_out_valid, n_out_data, DW'(i));
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        #1;
        n_cmp++; if (s_out_valid !== 1'b0 || s_out_data !== '0) begin
            n_err++; $display("FAIL stream_drain got=%b/%h exp=0/0", s_out_valid, s_out_data);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, DW'(8'h11), 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'(8'h22), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (s_occ !== 2'd2) begin n_err++; $display("FAIL bp_occ got=%0d exp=2", s_occ); end
        n_cmp++; if (s_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b exp=0", s_in_ready); end
        n_cmp++; if (s_out_data !== DW'(8'h11)) begin n_err++; $display("FAIL bp_head got=%h exp=11", s_out_data); end
        n_cmp++; if (n_occ !== 2'd1 || n_out_data !== DW'(8'h11)) begin
            n_err++; $display("FAIL bp_noskid got=%0d/%h exp=1/11", n_occ, n_out_data);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        #1;
        n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== DW'(8'h22)) begin
            n_err++; $display("FAIL bp_second got=%b/%h exp=1/22", s_out_valid, s_out_data);
        end
        n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back got=%b exp=1", s_in_ready); end
        tick();
        #1;
        n_cmp++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin
            n_err++; $display("FAIL bp_empty got=%b/%0d exp=0/0", s_out_valid, s_occ);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, DW'(8'h11), 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'(8'h22), 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'(8'h33), 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (s_occ !== 2'd0 || s_out_valid !== 1'b0 || s_out_data !== '0) begin
            n_err++; $display("FAIL flush_clear got=%0d/%b/%h exp=0/0/0", s_occ, s_out_valid, s_out_data);
        end
        n_cmp++; if (n_occ !== 2'd0 || n_out_data !== '0) begin
            n_err++; $display("FAIL flush_clear_n got=%0d/%h exp=0/0", n_occ, n_out_data);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_cmp++; if (s_out_valid !== 1'b0 || s_out_data === DW'(8'h33)) begin
                n_err++; $display("FAIL flush_ghost i=%0d got=%b/%h exp=0/0", i, s_out_valid, s_out_data);
            end
        end
    endtask

    task automatic test_noskid();
        drive(1'b1, DW'(8'h55), 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'(8'h44), 1'b1, 1'b0);
        n_cmp++; if (n_in_ready !== 1'b1 || n_out_data !== DW'(8'h55)) begin
            n_err++; $display("FAIL noskid_comb_ready got=%b/%h exp=1/55", n_in_ready, n_out_data);
        end
        tick();
        #1;
        n_cmp++; if (n_out_valid !== 1'b1 || n_out_data !== DW'(8'h44)) begin
            n_err++; $display("FAIL noskid_replace got=%b/%h exp=1/44", n_out_valid, n_out_data);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        #1;
        n_cmp++; if (n_out_valid !== 1'b0 || n_out_data !== '0) begin
            n_err++; $display("FAIL noskid_drain got=%b/%h exp=0/0", n_out_valid, n_out_data);
        end
    endtask

    task automatic test_random();
        logic          e_rdy;
        logic [DW-1:0] e_dat;
        for (int c = 0; c < 2000; c++) begin
            drive(($urandom_range(0, 9) < 7), {$urandom(), $urandom()},
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0));
            if (c == 1000) begin
                do_reset();
                n_cmp++; if (s_occ !== 2'd0 || n_occ !== 2'd0 || s_out_data !== '0) begin
                    n_err++; $display("FAIL rnd_midreset got=%0d/%0d/%h exp=0/0/0", s_occ, n_occ, s_out_data);
                end
                tick();
                rst = 1'b1;
                #1;
            end
            e_rdy = rst && s_live && (qs.size() < 2);
            e_dat = (qs.size() > 0) ? qs[0] : '0;
            n_cmp++; if (s_in_ready !== e_rdy) begin n_err++; $display("FAIL rnd_s_in_ready c=%0d got=%b exp=%b", c, s_in_ready, e_rdy); end
            n_cmp++; if (s_out_valid !== (qs.size() > 0)) begin n_err++; $display("FAIL rnd_s_out_valid c=%0d got=%b exp=%b", c, s_out_valid, qs.size() > 0); end
            n_cmp++; if (s_out_data !== e_dat) begin n_err++; $display("FAIL rnd_s_out_data c=%0d got=%h exp=%h", c, s_out_data, e_dat); end
            n_cmp++; if (s_occ !== 2'(qs.size())) begin n_err++; $display("FAIL rnd_s_occ c=%0d got=%0d exp=%0d", c, s_occ, qs.size()); end
            e_rdy = rst && ((qn.size() == 0) || out_ready);
            e_dat = (qn.size() > 0) ? qn[0] : '0;
            n_cmp++; if (n_in_ready !== e_rdy) begin n_err++; $display("FAIL rnd_n_in_ready c=%0d got=%b exp=%b", c, n_in_ready, e_rdy); end
            n_cmp++; if (n_out_data !== e_dat) begin n_err++; $display("FAIL rnd_n_out_data c=%0d got=%h exp=%h", c, n_out_data, e_dat); end
            n_cmp++; if (n_occ !== 2'(qn.size())) begin n_err++; $display("FAIL rnd_n_occ c=%0d got=%0d exp=%0d", c, n_occ, qn.size()); end
`ifdef PIPE_STAGE_PERF_EN
            n_cmp++; if (s_stall !== PW'(m_stall) || s_bubble !== PW'(m_bubble) || s_flush !== PW'(m_flush)) begin
                n_err++; $display("FAIL rnd_perf c=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                                  c, s_stall, s_bubble, s_flush, m_stall, m_bubble, m_flush);
            end
`endif
            tick();
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        drive(1'b0, '0, 1'b0, 1'b0);
        do_reset();
        tick();
        rst = 1'b1;
        drive(1'b1, DW'(8'h66), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        n_cmp++; if (s_stall !== PW'(PMAX) || m_stall != PMAX) begin
            n_err++; $display("FAIL perf_stall_sat got=%0d exp=%0d", s_stall, PMAX);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (s_flush !== PW'(3)) begin n_err++; $display("FAIL perf_flush got=%0d exp=3", s_flush); end
        n_cmp++; if (s_bubble !== PW'(m_bubble)) begin n_err++; $display("FAIL perf_bubble got=%0d exp=%0d", s_bubble, m_bubble); end
    endtask
`endif

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        s_live    = 1'b0;
        m_stall   = 0;
        m_bubble  = 0;
        m_flush   = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_noskid();
        test_random();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_rv.md
Name: pipe_stage_rv

Overview:
- Parametrised ready/valid pipeline stage register; successor to the fixed fetch->decode stall/bubble register.
- Carries an opaque DATA_W payload (pc, instr, commit info concatenated by the instantiator) between any two stages of the rv64 pipeline.
- Adds a valid/ready handshake, an optional two-entry skid buffer that registers in_ready, and a synchronous flush.

Parameters:
- DATA_W, 257: payload width (64 pc + 32 instr + 161 commit info).
- SKID_EN, 1: 1 selects the two-entry skid buffer with a registered in_ready; 0 selects a single register with a combinational in_ready.
- PERF_W, 32: width of the performance counters; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  synchronous flush; squashes all held entries
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream payload valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  downstream payload
- occupancy  out  2  entries held (0..2; max 1 when SKID_EN=0)

Behaviour:
- State: main_v/main_d, skid_v/skid_d. Handshake events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Outputs:
  - out_valid = main_v; out_data = main_d.
  - occupancy = main_v + skid_v.
- Reset (rst low, asynchronous):
  - All valid bits and data registers go to 0; occupancy = 0.
  - in_ready is forced to 0 while rst is low.
  - Reset asserted mid-transfer drops everything held; no partial payload survives.
- Flush (highest synchronous priority):
  - At the clock edge, main_v, skid_v, main_d and skid_d all go to 0.
  - Any in_fire in the same cycle is discarded.
  - out_fire in the flush cycle still counts as a completed transfer downstream.
- Data cleanliness: main_d is zeroed whenever main_v goes to 0 without a refill, so out_data == 0 whenever out_valid == 0 (downstream sees a nop commit).
- SKID_EN=1:
  - in_ready = ~skid_v (registered; no combinational path from out_ready).
  - skid_v=1 and out_fire: main <- skid, skid_v <- 0.
  - skid_v=0 and (~main_v | out_fire): main_v <- in_fire, main_d <- in_data when in_fire.
  - skid_v=0, main_v=1, ~out_ready and in_fire: skid <- in_data, skid_v <- 1.
  - Full (occupancy 2): in_ready = 0 until out_fire; in_ready returns to 1 the cycle after that out_fire.
- SKID_EN=0:
  - in_ready = ~main_v | out_ready (combinational). Skid registers are constant 0.
  - Simultaneous in_fire and out_fire replaces main with no bubble.
- Latency: 1 cycle from in_fire to out_valid. Full throughput (1 per cycle) in both modes when out_ready is held high.
- Ordering: strict FIFO; no duplication, no loss except through flush or reset.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, adds three output ports, each PERF_W wide, saturating at all-ones and reset to 0 (by rst, not by flush):
  - stall_cnt: cycles with out_valid & ~out_ready.
  - bubble_cnt: cycles with ~out_valid.
  - flush_cnt: cycles with flush high.
- When undefined: the ports and logic are absent, and the handshake behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds PC_W=64, INSTR_W=32, COMMIT_W=161, FD_PAYLOAD_W=PC_W+INSTR_W+COMMIT_W, and a packed struct for the fetch->decode payload.
- Natural sub-module: pipe_stage_perf (the saturating counters), instantiated only under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: rst low with in_valid=1 and in_data=0xABC -> in_ready=0, out_valid=0, out_data=0, occupancy=0; rst high -> in_ready=1 on the next cycle (SKID_EN=1).
- Streaming: out_ready=1, push payloads 1..8 back-to-back -> out_data 1..8 on consecutive cycles, each 1 cycle after its push, no gaps.
- Backpressure into skid: push A=0x11, B=0x22 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x11; release out_ready -> 0x11 then 0x22 out, in_ready=1 the cycle after the first pop.
- Flush with full buffer and in_fire in the same cycle (payload 0x33) -> next cycle occupancy=0, out_valid=0, out_data=0; 0x33 never appears downstream.
- SKID_EN=0: main full, out_ready=1 and in_valid=1 with 0x44 in the same cycle -> in_ready=1 combinationally, 0x44 valid next cycle, no bubble.
- PIPE_STAGE_PERF_EN with PERF_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15; flush for 3 cycles -> flush_cnt=3.
